// File: rtl/falafel_config_host_if.sv
// falafel_config_host_if: host command initiator for the falafel config register block.
// One command in flight: IDLE accepts, EXEC strobes/decodes, RESP holds the response.
package falafel_config_pkg;
  localparam int FLP_W = 16;
  localparam logic [31:0] FREE_LIST_PTR_ADDR = 32'h0000_0010;
  typedef struct packed {
    logic [FLP_W-1:0] free_list_ptr;
  } config_regs_t;
endpackage

module falafel_config_host_if
  import falafel_config_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [DATA_W-1:0]    req_addr_i,
  input  logic [DATA_W-1:0]    req_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DATA_W-1:0]    rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic                 cfg_write_o,
  output logic [DATA_W-1:0]    cfg_addr_o,
  output logic [DATA_W-1:0]    cfg_data_o,
  input  config_regs_t         config_i,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t r_state, w_next;
  logic r_we, r_err;
  logic [DATA_W-1:0] r_addr, r_wdata, r_rdata;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic w_hit;
  assign w_hit = r_addr == DATA_W'(FREE_LIST_PTR_ADDR);
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && req_valid_i) w_next = EXEC;
    else if (r_state == EXEC) w_next = RESP;
    else if (r_state == RESP && rsp_ready_i) w_next = IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && req_valid_i) begin
        r_we    <= req_we_i;
        r_addr  <= req_addr_i;
        r_wdata <= req_wdata_i;
      end
      if (r_state == EXEC) begin
        r_err   <= !w_hit;
        r_rdata <= (!r_we && w_hit) ? DATA_W'(config_i.free_list_ptr) : '0;
        if (!w_hit && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end
  assign req_ready_o = r_state == IDLE;
  assign rsp_valid_o = r_state == RESP;
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;
  assign cfg_write_o = r_state == EXEC && r_we && w_hit;
  assign cfg_addr_o  = cfg_write_o ? r_addr : '0;
  assign cfg_data_o  = cfg_write_o ? r_wdata : '0;
  assign err_cnt_o   = r_err_cnt;
endmodule

// File: tb/tb_falafel_config_host_if.sv
// tb_falafel_config_host_if: directed bench with a timeline model of command/response behaviour.
module tb_falafel_config_host_if;
  import falafel_config_pkg::*;
  localparam logic [31:0] FLP = FREE_LIST_PTR_ADDR;
  localparam logic [31:0] BAD = 32'hDEAD_BEEC;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready, req_we = 1'b0, rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] req_addr = '0, req_wdata = '0, rsp_rdata, cfg_addr, cfg_data;
  logic cfg_write;
  logic [7:0] err_cnt;
  logic [15:0] reg_flp = '0;
  config_regs_t cfg;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  assign cfg.free_list_ptr = reg_flp;
  falafel_config_host_if #(.DATA_W(32), .ERR_CNT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .cfg_write_o(cfg_write), .cfg_addr_o(cfg_addr), .cfg_data_o(cfg_data),
    .config_i(cfg), .err_cnt_o(err_cnt)
  );
  // Emulated config register block: not reset, takes strobed writes at its address
  always @(posedge clk) if (cfg_write && cfg_addr == FLP) reg_flp <= cfg_data[15:0];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Model: a command accepted in cycle t strobes/decodes in t+1 and responds from t+2
  int cyc = 0, t = 0;
  logic pend = 1'b0, m_we = 1'b0, m_err = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic [15:0] shadow = '0;
  logic [7:0] m_cnt = '0;
  always @(posedge clk or negedge rst_n) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      pend  <= 1'b0;
      m_cnt <= '0;
    end else if (!pend && req_valid) begin
      pend <= 1'b1; t <= cyc; m_we <= req_we; m_addr <= req_addr; m_wdata <= req_wdata;
    end else if (pend && cyc == t + 1) begin
      m_err   <= m_addr != FLP;
      m_rdata <= (!m_we && m_addr == FLP) ? {16'h0, shadow} : 32'h0;
      if (m_we && m_addr == FLP) shadow <= m_wdata[15:0];
      if (m_addr != FLP && m_cnt != 8'hFF) m_cnt <= m_cnt + 8'd1;
    end else if (pend && cyc >= t + 2 && rsp_ready) pend <= 1'b0;
  end
  always @(negedge clk) if (rst_n) begin
    logic s;
    s = pend && cyc == t + 1 && m_we && m_addr == FLP;
    chk("req_ready", req_ready, !pend);
    chk("cfg_write", cfg_write, s);
    chk("cfg_addr", cfg_addr, s ? m_addr : 32'h0);
    chk("cfg_data", cfg_data, s ? m_wdata : 32'h0);
    chk("rsp_valid", rsp_valid, pend && cyc >= t + 2);
    chk("err_cnt", err_cnt, m_cnt);
    if (pend && cyc >= t + 2) begin
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_err", rsp_err, m_err);
    end
  end
  task automatic cmd(input logic we, input logic [31:0] a, input logic [31:0] d,
                     output logic sw, output logic [31:0] swa, output logic [31:0] swd,
                     output logic [31:0] rd, output logic e);
    int n;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (n == 50) chk("ready_timeout", 1, 0);
    @(negedge clk);
    req_valid = 1'b0;
    sw = cfg_write; swa = cfg_addr; swd = cfg_data;
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    if (n == 50) chk("rsp_timeout", 1, 0);
    rd = rsp_rdata; e = rsp_err;
    @(negedge clk);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic sw, e;
    logic [31:0] swa, swd, rd, rd0;
    int n;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cfg_write", cfg_write, 0);
    chk("rst_err_cnt", err_cnt, 0);
    cmd(1'b1, FLP, 32'h0000_1000, sw, swa, swd, rd, e);
    chk("wr_strobe", sw, 1); chk("wr_addr", swa, 32'h0000_0010); chk("wr_data", swd, 32'h0000_1000);
    chk("wr_err", e, 0); chk("wr_rdata", rd, 0); chk("reg_value", reg_flp, 16'h1000);
    cmd(1'b0, FLP, 32'h0, sw, swa, swd, rd, e);
    chk("raw_rdata", rd, 32'h0000_1000); chk("raw_err", e, 0); chk("rd_strobe", sw, 0);
    cmd(1'b0, BAD, 32'h0, sw, swa, swd, rd, e);
    chk("bad_rd_err", e, 1); chk("bad_rd_rdata", rd, 0); chk("bad_rd_strobe", sw, 0); chk("cnt1", err_cnt, 1);
    cmd(1'b1, BAD, 32'h5555_AAAA, sw, swa, swd, rd, e);
    chk("bad_wr_err", e, 1); chk("bad_wr_rdata", rd, 0); chk("bad_wr_strobe", sw, 0); chk("cnt2", err_cnt, 2);
    chk("reg_unchanged", reg_flp, 16'h1000);
    // Backpressure with a second request queued behind the stalled response
    rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = FLP;
    @(negedge clk);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    rd0 = rsp_rdata;
    chk("bp_rdata", rd0, 32'h0000_1000);
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1); chk("bp_stable", rsp_rdata, rd0); chk("bp_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_drop", rsp_valid, 0); chk("bp_idle_ready", req_ready, 1);
    @(negedge clk);
    chk("bp_queued_accept", req_ready, 0);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_queued_rdata", rsp_rdata, 32'h0000_1000);
    @(negedge clk);
    for (int i = 0; i < 260; i++) cmd(1'b1, BAD, i, sw, swa, swd, rd, e);
    chk("cnt_sat", err_cnt, 8'hFF);
    // Async reset in the middle of an EXEC write
    req_valid = 1'b1; req_we = 1'b1; req_addr = FLP; req_wdata = 32'h0000_2222;
    @(posedge clk);
    #2;
    chk("exec_strobe", cfg_write, 1);
    rst_n = 1'b0; req_valid = 1'b0;
    #1;
    chk("arst_strobe", cfg_write, 0); chk("arst_valid", rsp_valid, 0);
    chk("arst_cnt", err_cnt, 0); chk("arst_ready", req_ready, 1); chk("arst_addr", cfg_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_no_write", reg_flp, 16'h1000);
    cmd(1'b1, FLP, 32'h0000_3000, sw, swa, swd, rd, e);
    chk("post_strobe", sw, 1); chk("post_data", swd, 32'h0000_3000); chk("post_err", e, 0);
    cmd(1'b0, FLP, 32'h0, sw, swa, swd, rd, e);
    chk("post_rdata", rd, 32'h0000_3000);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
